// File: rtl/button_pkg.sv
// Shared button types and default 50 MHz timing constants for the button event decoder.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESSED     = 2'd1,
    WAIT_SECOND = 2'd2,
    HOLD        = 2'd3
  } btn_state_t;

  localparam int BTN_LONG_CYCLES   = 50_000_000;
  localparam int BTN_DBL_CYCLES    = 15_000_000;
  localparam int BTN_REPEAT_CYCLES = 10_000_000;

endpackage

// File: rtl/button_event_decoder_edge_detect.sv
// Registers a synchronous level and produces same-cycle and registered rise/fall indications.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o,
  output logic rise_q_o,
  output logic fall_q_o
);

  logic sig_q;
  logic rise_q;
  logic fall_q;

  assign rise_o   = sig_i & ~sig_q;
  assign fall_o   = ~sig_i & sig_q;
  assign rise_q_o = rise_q;
  assign fall_q_o = fall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sig_q  <= sig_i;
      rise_q <= rise_o;
      fall_q <= fall_o;
    end
  end

endmodule

// File: rtl/button_event_decoder.sv
// Classifies a debounced button level into press/release/short/long/double-click pulses.
// Optional auto-repeat while long-held is enabled by defining BUTTON_EVENT_REPEAT_EN.
module button_event_decoder
  import button_pkg::*;
#(
  parameter int LONG_CYCLES   = BTN_LONG_CYCLES,
  parameter int DBL_CYCLES    = BTN_DBL_CYCLES,
  parameter int CNT_W         = 26,
  parameter int REPEAT_CYCLES = BTN_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic busy
`ifdef BUTTON_EVENT_REPEAT_EN
  ,
  output logic repeat_pulse
`endif
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic       rise;
  logic       fall;
  btn_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic short_q, short_d;
  logic long_q, long_d;
  logic dbl_q, dbl_d;
  logic busy_q;

  edge_detect u_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .sig_i    (pb_state),
    .rise_o   (rise),
    .fall_o   (fall),
    .rise_q_o (press_pulse),
    .fall_q_o (release_pulse)
  );

`ifdef BUTTON_EVENT_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic rep_arm_q, rep_arm_d;
  logic rep_q, rep_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = sat_inc(cnt_q);
    short_d = 1'b0;
    long_d  = 1'b0;
    dbl_d   = 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
    rep_arm_d = rep_arm_q;
    rep_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rise) state_d = PRESSED;
      end
      PRESSED: begin
        // A release landing on the expiry cycle wins over long_press.
        if (fall) begin
          state_d = WAIT_SECOND;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = HOLD;
          cnt_d   = '0;
`ifdef BUTTON_EVENT_REPEAT_EN
          rep_arm_d = 1'b1;
`endif
        end
      end
      WAIT_SECOND: begin
        if (rise) begin
          dbl_d   = 1'b1;
          state_d = HOLD;
          cnt_d   = '0;
`ifdef BUTTON_EVENT_REPEAT_EN
          rep_arm_d = 1'b0;
`endif
        end else if (cnt_q == DBL_LAST) begin
          short_d = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (fall) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
`ifdef BUTTON_EVENT_REPEAT_EN
        else if (rep_arm_q && cnt_q == REP_LAST) begin
          rep_d = 1'b1;
          cnt_d = '0;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      dbl_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      short_q <= short_d;
      long_q  <= long_d;
      dbl_q   <= dbl_d;
      busy_q  <= (state_d != IDLE);
    end
  end

`ifdef BUTTON_EVENT_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_arm_q <= 1'b0;
      rep_q     <= 1'b0;
    end else begin
      rep_arm_q <= rep_arm_d;
      rep_q     <= rep_d;
    end
  end

  assign repeat_pulse = rep_q;
`endif

  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_click = dbl_q;
  assign busy         = busy_q;

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Consumes the debounced, synchronised push-button level (pb_state, high = pressed) produced by the debouncer stage.
- Classifies button activity into single-cycle event pulses: press, release, short press, long press and double click.
- Sits between the debouncer and the control/UI logic (mode selection, counters, menu stepping), so that downstream blocks never time button presses themselves.

Parameters:
- LONG_CYCLES, 50_000_000: hold time in clk cycles for a long press (1 s at 50 MHz); must be >= 2.
- DBL_CYCLES, 15_000_000: window in clk cycles after a short release in which a second press counts as a double click (300 ms); must be >= 2.
- CNT_W, 26: counter width; must satisfy 2**CNT_W > max(LONG_CYCLES, DBL_CYCLES, REPEAT_CYCLES).
- REPEAT_CYCLES, 10_000_000: auto-repeat period (only used when REPEAT_EN is defined).

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- pb_state  in  1  debounced button level, already synchronous to clk
- press_pulse  out  1  one-cycle pulse on every 0->1 of pb_state
- release_pulse  out  1  one-cycle pulse on every 1->0 of pb_state
- short_press  out  1  one-cycle pulse: single press released before LONG_CYCLES, no second press within DBL_CYCLES
- long_press  out  1  one-cycle pulse when a first press has been held LONG_CYCLES cycles
- double_click  out  1  one-cycle pulse on the second press of a double click
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Single clock domain; reset is asynchronous and active-low (rst_n). Clock port is clk. All outputs are registered.
- Reset values:
  - All pulse outputs 0 and busy 0.
  - Edge register pb_q = 0, counter = 0, FSM = IDLE.
  - A button already held when rst_n deasserts is treated as a fresh press.
- Edge detect:
  - rise = pb_state & ~pb_q; fall = ~pb_state & pb_q.
  - press_pulse and release_pulse are high in the cycle after the edge cycle (latency 1), in every state.
- FSM states: IDLE, PRESSED, WAIT_SECOND, HOLD.
  - IDLE:
    - rise -> PRESSED, cnt <= 0.
  - PRESSED:
    - cnt increments each cycle.
    - fall before expiry -> WAIT_SECOND, cnt <= 0.
    - When cnt == LONG_CYCLES-1 with pb_state still high: pulse long_press, -> HOLD.
    - If fall and expiry coincide, fall wins: no long_press, go to WAIT_SECOND.
  - WAIT_SECOND:
    - cnt increments each cycle.
    - rise -> pulse double_click, -> HOLD.
    - When cnt == DBL_CYCLES-1 with no rise: pulse short_press, -> IDLE.
    - If rise and expiry coincide, rise wins: double_click only, no short_press.
  - HOLD:
    - Waits for fall, then -> IDLE.
    - No further short, long or double events until release.
- Event timing and exclusivity:
  - Event pulses are asserted the cycle after the triggering condition.
  - At most one of short_press, long_press and double_click is high in any cycle.
- Counter: saturates (never wraps) and is cleared on every state entry.
- Reset mid-operation: FSM returns to IDLE immediately. No pending event is emitted after reset release.

Optional Feature:
- Macro: BUTTON_EVENT_REPEAT_EN.
- Defined:
  - Adds output repeat_pulse (1 bit, reset 0).
  - In HOLD entered via long_press, repeat_pulse fires once every REPEAT_CYCLES cycles while held. The first repeat comes REPEAT_CYCLES after long_press.
  - HOLD entered via double_click never repeats.
- Undefined: no repeat_pulse port and no repeat counter logic; HOLD just waits for release.

Decomposition:
- Shared package button_pkg holds:
  - the FSM state typedef (btn_state_t: IDLE, PRESSED, WAIT_SECOND, HOLD);
  - default cycle constants for 50 MHz (BTN_LONG_CYCLES, BTN_DBL_CYCLES, BTN_REPEAT_CYCLES).
- One natural sub-module: edge_detect (registers pb_q and produces registered rise/fall pulses). It is reusable for other debounced inputs.
- FSM and counter stay in the top module.

Test Plan (LONG_CYCLES=20, DBL_CYCLES=8, REPEAT_CYCLES=5):
- Reset: hold rst_n=0 with pb_state toggling -> all outputs 0, busy 0. Release with pb_state=1 -> press_pulse 1 cycle later.
- Short press: pb_state high 5 cycles then low -> press_pulse, release_pulse, then short_press exactly once, 8 cycles after the fall edge. No long_press, busy returns to 0.
- Long press: pb_state high 30 cycles -> long_press exactly once at cycle 20 after the rise, nothing more until release. Release -> release_pulse only.
- Double click: press 3, release 4, press 3 -> double_click on the second rise+1. No short_press at any time.
- Boundary races:
  - release exactly on cycle LONG_CYCLES-1 -> no long_press;
  - second press exactly on DBL_CYCLES-1 -> double_click, no short_press;
  - rst_n pulse low during WAIT_SECOND -> no short_press emitted.
- BUTTON_EVENT_REPEAT_EN defined: hold 37 cycles -> long_press at 20, repeat_pulse at 25, 30, 35. Double-click hold -> no repeat_pulse.
